// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: drives datapath enables and mux selects per step.
// Optional illegal-instruction trap state enabled by defining MC_CTRL_TRAP_EN.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Trap
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB,
      EXECUTER, EXECUTEI, JAL, ALUWB, BEQ, TRAP
   } state_t;

   state_t     state, state_next;
   logic       pc_update, branch, ir_write, mem_write, reg_write;
   logic [2:0] alu_decoded;
`ifdef MC_CTRL_TRAP_EN
   logic       trap_state;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   // Subtract only for R-type with funct7b5 set; immediates reuse bit 30 as immediate data.
   always_comb begin
      alu_decoded = 3'b000;
      case (funct3)
         3'b000:  alu_decoded = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
         3'b010:  alu_decoded = 3'b101;
         3'b110:  alu_decoded = 3'b011;
         3'b111:  alu_decoded = 3'b010;
         default: alu_decoded = 3'b000;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   always_comb begin
      state_next = state;
      pc_update  = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
`ifdef MC_CTRL_TRAP_EN
      trap_state = 1'b0;
`endif
      case (state)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (MemReady) begin
               ir_write   = 1'b1;
               pc_update  = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECUTER;
               OP_I:         state_next = EXECUTEI;
               OP_JAL:       state_next = JAL;
               OP_BEQ:       state_next = BEQ;
`ifdef MC_CTRL_TRAP_EN
               default:      state_next = TRAP;
`else
               default:      state_next = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) state_next = MEMWB;
         end
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
            if (MemReady) state_next = FETCH;
         end
         MEMWB: begin
            ResultSrc  = 2'b01;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         EXECUTER: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_decoded;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_decoded;
            state_next = ALUWB;
         end
         JAL: begin
            // Jump target was computed in DECODE; ALU now forms the link address.
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pc_update  = 1'b1;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BEQ: begin
            ALUSrcA    = 2'b10;
            ALUControl = 3'b001;
            branch     = 1'b1;
            state_next = FETCH;
         end
`ifdef MC_CTRL_TRAP_EN
         TRAP: begin
            trap_state = 1'b1;
            state_next = TRAP;
         end
`endif
         default: state_next = FETCH;
      endcase
   end

   assign PCWrite  = ~reset & (pc_update | (branch & Zero));
   assign IRWrite  = ~reset & ir_write;
   assign MemWrite = ~reset & mem_write;
   assign RegWrite = ~reset & reg_write;
`ifdef MC_CTRL_TRAP_EN
   assign Trap = ~reset & trap_state;
`else
   assign Trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller, plus hand-written CPI and illegal-opcode sequences.
// The illegal-opcode expectations follow MC_CTRL_TRAP_EN.
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_ILL = 7'b1111111;

   // Care masks over {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}.
   localparam logic [4:0] MF = 5'b11111;
   localparam logic [4:0] MD = 5'b00111;
   localparam logic [4:0] MM = 5'b11000;
   localparam logic [4:0] MW = 5'b01000;
   localparam logic [4:0] MJ = 5'b01111;
   localparam logic [4:0] MN = 5'b00000;

   typedef struct {
      logic       rst;
      logic [6:0] opc;
      logic [2:0] f3;
      logic       f7, z, mr;
      logic       pcw, mw, irw, rw, trp;
      logic       adr;
      logic [1:0] rs, asa, asb, imm;
      logic [2:0] alu;
      logic [4:0] care;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = OP_R;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b1;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Trap;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   vec_t vecs[$];
   int   num_checks = 0;
   int   num_fail = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Trap(Trap)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] imm_for(input logic [6:0] opc);
      if (opc == OP_SW)  return 2'b01;
      if (opc == OP_BEQ) return 2'b10;
      if (opc == OP_JAL) return 2'b11;
      return 2'b00;
   endfunction

   task automatic add_vec(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic z, input logic mr,
                          input logic pcw, input logic mw, input logic irw, input logic rw,
                          input logic trp, input logic adr, input logic [1:0] rs,
                          input logic [1:0] asa, input logic [1:0] asb, input logic [2:0] alu,
                          input logic [4:0] care);
      vec_t v;
      v.rst = rst; v.opc = opc; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr;
      v.pcw = pcw; v.mw = mw; v.irw = irw; v.rw = rw; v.trp = trp;
      v.adr = adr; v.rs = rs; v.asa = asa; v.asb = asb; v.alu = alu;
      v.imm = imm_for(opc); v.care = care;
      vecs.push_back(v);
   endtask

   task automatic apply_stimulus(input vec_t v);
      reset = v.rst; op = v.opc; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; MemReady = v.mr;
   endtask

   task automatic check_output(input int idx, input vec_t v);
      logic       ok;
      logic [4:0] act_en, exp_en;
      act_en = {PCWrite, MemWrite, IRWrite, RegWrite, Trap};
      exp_en = {v.pcw, v.mw, v.irw, v.rw, v.trp};
      ok = (act_en === exp_en);
      if (v.care[4] && AdrSrc !== v.adr)     ok = 1'b0;
      if (v.care[3] && ResultSrc !== v.rs)   ok = 1'b0;
      if (v.care[2] && ALUSrcA !== v.asa)    ok = 1'b0;
      if (v.care[1] && ALUSrcB !== v.asb)    ok = 1'b0;
      if (v.care[0] && ALUControl !== v.alu) ok = 1'b0;
      if (v.opc != OP_R && ImmSrc !== v.imm) ok = 1'b0;
      num_checks++;
      if (!ok) begin
         num_fail++;
         $display("[TB] FAIL vec %0d: got en=%b adr=%b rs=%b asa=%b asb=%b alu=%b imm=%b, expected en=%b adr=%b rs=%b asa=%b asb=%b alu=%b imm=%b care=%b",
                  idx, act_en, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
                  exp_en, v.adr, v.rs, v.asa, v.asb, v.alu, v.imm, v.care);
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Counts cycles from one instruction's FETCH to the next with memory always ready.
   task automatic measure_cpi(input string name, input logic [6:0] opc, input int exp_cpi);
      int cycles;
      @(negedge clk);
      reset = 1'b0; op = opc; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      #2;
      chk({name, " fetch"}, {7'b0, IRWrite}, 8'd1);
      cycles = 1;
      while (cycles < 20) begin
         @(negedge clk);
         #2;
         if (IRWrite) break;
         cycles++;
      end
      MemReady = 1'b0;
      chk({name, " cpi"}, cycles[7:0], exp_cpi[7:0]);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // rst op f3 f7 z mr | pcw mw irw rw trp | adr rs asa asb alu | care
      add_vec(1, OP_R, 3'd0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd0, 2'd0, 3'd0, MN);
      add_vec(1, OP_R, 3'd0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd0, 2'd0, 3'd0, MN);
      // add, sub, slt
      for (int k = 0; k < 3; k++) begin
         logic [2:0] f3;
         logic       f7;
         logic [2:0] alu;
         f3  = (k == 2) ? 3'd2 : 3'd0;
         f7  = (k == 1);
         alu = (k == 0) ? 3'b000 : ((k == 1) ? 3'b001 : 3'b101);
         add_vec(0, OP_R, f3, f7, 0, 1,  1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
         add_vec(0, OP_R, f3, f7, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
         add_vec(0, OP_R, f3, f7, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd2, 2'd0, alu,  MD);
         add_vec(0, OP_R, f3, f7, 0, 1,  0, 0, 0, 1, 0,  0, 2'd0, 2'd0, 2'd0, 3'd0, MW);
      end
      // addi with funct7b5=1, ori, andi; Zero held high must not affect PCWrite
      for (int k = 0; k < 3; k++) begin
         logic [2:0] f3;
         logic [2:0] alu;
         f3  = (k == 0) ? 3'd0 : ((k == 1) ? 3'd6 : 3'd7);
         alu = (k == 0) ? 3'b000 : ((k == 1) ? 3'b011 : 3'b010);
         add_vec(0, OP_I, f3, 1, 1, 1,  1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
         add_vec(0, OP_I, f3, 1, 1, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
         add_vec(0, OP_I, f3, 1, 1, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd2, 2'd1, alu,  MD);
         add_vec(0, OP_I, f3, 1, 1, 1,  0, 0, 0, 1, 0,  0, 2'd0, 2'd0, 2'd0, 3'd0, MW);
      end
      // lw with two stalled MEMREAD cycles
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd2, 2'd1, 3'd0, MD);
      add_vec(0, OP_LW, 3'd2, 0, 0, 0,  0, 0, 0, 0, 0,  1, 2'd0, 2'd0, 2'd0, 3'd0, MM);
      add_vec(0, OP_LW, 3'd2, 0, 0, 0,  0, 0, 0, 0, 0,  1, 2'd0, 2'd0, 2'd0, 3'd0, MM);
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 0, 0,  1, 2'd0, 2'd0, 2'd0, 3'd0, MM);
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 1, 0,  0, 2'd1, 2'd0, 2'd0, 3'd0, MW);
      // sw: stalled FETCH, MemReady ignored in DECODE/MEMADR, three stalled MEMWRITE cycles
      add_vec(0, OP_SW, 3'd2, 0, 0, 0,  0, 0, 0, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
      add_vec(0, OP_SW, 3'd2, 0, 0, 1,  1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
      add_vec(0, OP_SW, 3'd2, 0, 0, 0,  0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
      add_vec(0, OP_SW, 3'd2, 0, 0, 0,  0, 0, 0, 0, 0,  0, 2'd0, 2'd2, 2'd1, 3'd0, MD);
      for (int k = 0; k < 4; k++)
         add_vec(0, OP_SW, 3'd2, 0, 0, (k == 3), 0, 1, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, MM);
      // beq taken and not taken; Zero high in DECODE must not write PC
      for (int k = 0; k < 2; k++) begin
         logic z;
         z = (k == 0);
         add_vec(0, OP_BEQ, 3'd0, 0, z, 1,  1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
         add_vec(0, OP_BEQ, 3'd0, 0, z, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
         add_vec(0, OP_BEQ, 3'd0, 0, z, 1,  z, 0, 0, 0, 0,  0, 2'd0, 2'd2, 2'd0, 3'd1, MJ);
      end
      // jal
      add_vec(0, OP_JAL, 3'd0, 0, 0, 1,  1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
      add_vec(0, OP_JAL, 3'd0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
      add_vec(0, OP_JAL, 3'd0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd2, 3'd0, MJ);
      add_vec(0, OP_JAL, 3'd0, 0, 0, 1,  0, 0, 0, 1, 0,  0, 2'd0, 2'd0, 2'd0, 3'd0, MW);
      // lw interrupted by reset in MEMWB, then an add from a clean FETCH
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd2, 2'd1, 3'd0, MD);
      add_vec(0, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 0, 0,  1, 2'd0, 2'd0, 2'd0, 3'd0, MM);
      add_vec(1, OP_LW, 3'd2, 0, 0, 1,  0, 0, 0, 0, 0,  0, 2'd0, 2'd0, 2'd0, 3'd0, MN);
      add_vec(0, OP_R, 3'd0, 0, 0, 1,   1, 0, 1, 0, 0,  0, 2'd2, 2'd0, 2'd2, 3'd0, MF);
      add_vec(0, OP_R, 3'd0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 2'd0, 2'd1, 2'd1, 3'd0, MD);
      add_vec(0, OP_R, 3'd0, 0, 0, 1,   0, 0, 0, 0, 0,  0, 2'd0, 2'd2, 2'd0, 3'd0, MD);
      add_vec(0, OP_R, 3'd0, 0, 0, 1,   0, 0, 0, 1, 0,  0, 2'd0, 2'd0, 2'd0, 3'd0, MW);

      foreach (vecs[i]) begin
         @(negedge clk);
         apply_stimulus(vecs[i]);
         #2;
         check_output(i, vecs[i]);
      end

      measure_cpi("beq", OP_BEQ, 3);
      measure_cpi("addi", OP_I, 4);
      measure_cpi("sw", OP_SW, 4);
      measure_cpi("jal", OP_JAL, 4);
      measure_cpi("lw", OP_LW, 5);

      // Illegal opcode
      @(negedge clk);
      op = OP_ILL; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      #2;
      chk("ill fetch irwrite", {7'b0, IRWrite}, 8'd1);
      chk("ill fetch immsrc", {6'b0, ImmSrc}, 8'd0);
      @(negedge clk);
      #2;
      chk("ill decode enables", {4'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 8'd0);
`ifdef MC_CTRL_TRAP_EN
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         Zero = 1'b1;
         #2;
         chk("trap held", {7'b0, Trap}, 8'd1);
         chk("trap enables", {4'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 8'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      #2;
      chk("trap cleared by reset", {7'b0, Trap}, 8'd0);
      chk("reset enables", {4'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 8'd0);
      @(negedge clk);
      reset = 1'b0; op = OP_R; Zero = 1'b0;
      #2;
      chk("post-trap fetch irwrite", {7'b0, IRWrite}, 8'd1);
      chk("post-trap fetch alusrcb", {6'b0, ALUSrcB}, 8'd2);
      chk("post-trap trap", {7'b0, Trap}, 8'd0);
`else
      @(negedge clk);
      #2;
      chk("ill nop trap", {7'b0, Trap}, 8'd0);
      chk("ill nop fetch irwrite", {7'b0, IRWrite}, 8'd1);
      chk("ill nop fetch pcwrite", {7'b0, PCWrite}, 8'd1);
      chk("ill nop fetch alusrcb", {6'b0, ALUSrcB}, 8'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
